dp1_exerciser: RTL and testbench
================================

Name: dp1_exerciser

Overview:
- Stimulus-and-check engine for the DP1 3-in/3-out combinational function: drives the a,b,c inputs and checks the x,y,z outputs.
- On start, steps abc through all 8 vectors 000..111, holds each for a settle window, samples xyz, and compares it against the golden truth table.
- Reports pass/fail, mismatch count and first failing vector.
- Sits between board switches/buttons and the DP1 instance for on-board self-test.

Parameters:
- SETTLE_CYCLES, 2, cycles abc_out is held before the sample edge; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  level; sampled only in IDLE; begins a run
- xyz_in  in  3  {x,y,z} from the DUT, x = bit 2
- abc_out  out  3  {a,b,c} to the DUT, a = bit 2
- busy  out  1  high from the first DRIVE cycle through the last SAMPLE cycle
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 when the last completed run had zero mismatches
- err_count  out  4  mismatches in the last/current run, 0..8
- fail_valid  out  1  at least one mismatch in the current/last run
- first_fail  out  3  abc index of the first mismatch; valid when fail_valid=1

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values (rst_n=0 at a clk edge): FSM=IDLE, abc_out=000, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=000, settle counter=0.
- Golden table, index abc -> xyz: 0->010, 1->101, 2->010, 3->100, 4->011, 5->001, 6->000, 7->001.
- IDLE: abc_out=000, busy=0.
  - start=1 -> DRIVE on the next edge.
  - That same edge clears err_count, fail_valid, first_fail and pass, loads vector index 0 and settle counter 0.
- DRIVE: abc_out = index; busy=1; counter increments each cycle.
  - When counter = SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE: one cycle; abc_out still = index. xyz_in is compared to golden[index] at the edge leaving SAMPLE.
  - On mismatch, err_count increments.
  - If fail_valid=0, first_fail<=index and fail_valid<=1.
  - If index=7 -> DONE; else index+1 -> DRIVE with counter reset to 0.
- Per vector, abc_out holds for SETTLE_CYCLES+1 cycles. Full run is 8*(SETTLE_CYCLES+1) busy cycles; default = 24.
- DONE: one cycle; done=1, busy=0, abc_out returns to 000, pass <= (err_count==0) using the final count including the last compare. Unconditional -> IDLE.
- start while busy or in DONE: ignored; no restart or queueing. A start held high re-triggers from IDLE on the cycle after DONE.
- Results (pass, err_count, fail_valid, first_fail) hold until the next run starts or reset.
- Reset mid-run: abort immediately to reset values; no done pulse.
- Index wrap: 3-bit index never wraps, because the 7->DONE transition is taken explicitly.

Optional Feature:
- Macro EXERCISER_CAPTURE_EN.
- Defined:
  - Adds ports cap_idx (in, 3) and cap_data (out, 3), plus an 8x3 capture array.
  - Each SAMPLE edge writes xyz_in to entry[index].
  - cap_data = entry[cap_idx], combinational read of the registered array.
  - Array is cleared to 000 on reset only, not on start.
- Undefined: ports and array are absent; all other behaviour is identical.

Decomposition:
- Package dp1_pkg holds:
  - state enum (IDLE, DRIVE, SAMPLE, DONE)
  - NUM_VEC=8, VEC_W=3
  - golden table constant GOLDEN_XYZ[0:7]
- One natural sub-module: dp1_golden (combinational abc -> expected xyz lookup). It is reusable by benches as a reference model.

Test Plan:
- Good DUT (real DP1 model), SETTLE_CYCLES=2, start pulse -> abc_out sequence 0..7, each held 3 cycles; done at cycle 25 after start is sampled; pass=1, err_count=0, fail_valid=0.
- y stuck-at-0 fault -> mismatches at vectors 0, 2, 4; err_count=3, first_fail=000, pass=0.
- xyz_in forced 111 -> err_count=8, first_fail=000, pass=0; no overflow of the 4-bit count.
- start held high through a run, plus an extra start pulse at cycle 10 -> no restart mid-run; new run begins the cycle after done; results cleared at that start.
- rst_n=0 at vector 5 mid-run -> next edge: all outputs at reset values, no done pulse; subsequent start runs normally.
- EXERCISER_CAPTURE_EN defined, good DUT -> after done, cap_idx=0..7 reads 010,101,010,100,011,001,000,001.

Source files
------------

// File: rtl/dp1_pkg.sv
// Shared types and constants for the DP1 exerciser: FSM states, vector sizing
// and the golden DP1 truth table (index abc -> expected {x,y,z}).
// No ports; imported by dp1_golden and dp1_exerciser.
package dp1_pkg;

    localparam int NUM_VEC = 8;
    localparam int VEC_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Element 0 is the leftmost entry, so GOLDEN_XYZ[abc] reads naturally.
    localparam logic [0:NUM_VEC-1][VEC_W-1:0] GOLDEN_XYZ = {
        3'b010, 3'b101, 3'b010, 3'b100,
        3'b011, 3'b001, 3'b000, 3'b001
    };

    function automatic logic [VEC_W-1:0] golden_xyz(input logic [VEC_W-1:0] abc);
        return GOLDEN_XYZ[abc];
    endfunction

endpackage

// File: rtl/dp1_golden.sv
// Golden DP1 reference: combinational abc -> expected xyz lookup, zero latency.
// Ports: abc_i {a,b,c} vector index in; xyz_o expected {x,y,z} out.
// No state, no backpressure; reusable wherever a DP1 reference is needed.
module dp1_golden
    import dp1_pkg::*;
(
    input  logic [VEC_W-1:0] abc_i,
    output logic [VEC_W-1:0] xyz_o
);

    assign xyz_o = golden_xyz(abc_i);

endmodule

// File: rtl/dp1_exerciser.sv
// DP1 self-test engine: steps abc 0..7, holds each SETTLE_CYCLES+1 cycles, checks
// xyz against the golden table; a run takes 8*(SETTLE_CYCLES+1) busy cycles plus one
// DONE cycle. start is honoured only in IDLE (ignored while busy or in DONE).
// Ports: clk, rst_n (sync, active-low), start, xyz_in -> abc_out, busy, done, pass,
// err_count, fail_valid, first_fail. Optional capture of sampled xyz per vector is
// enabled by defining EXERCISER_CAPTURE_EN (adds cap_idx in, cap_data out).
module dp1_exerciser
    import dp1_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VEC_W-1:0] xyz_in,
    output logic [VEC_W-1:0] abc_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail
`ifdef EXERCISER_CAPTURE_EN
    ,
    input  logic [VEC_W-1:0] cap_idx,
    output logic [VEC_W-1:0] cap_data
`endif
);

    localparam logic [3:0]       CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(NUM_VEC - 1);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [VEC_W-1:0] abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       err_q, err_d;
    logic             fv_q, fv_d;
    logic [VEC_W-1:0] ff_q, ff_d;

    logic [VEC_W-1:0] exp_xyz;
    logic             mismatch;

    dp1_golden u_golden (
        .abc_i (idx_q),
        .xyz_o (exp_xyz)
    );

    assign mismatch = (xyz_in != exp_xyz);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fv_d    = fv_q;
        ff_d    = ff_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    if (!fv_q) begin
                        ff_d = idx_q;
                        fv_d = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    // pass is taken from err_d so the final compare is included
                    // and the result is visible alongside the done pulse.
                    state_d = DONE;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + VEC_W'(1);
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        abc_d  = busy_d ? idx_d : '0;
        done_d = (state_d == DONE);
    end

    assign abc_out    = abc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign first_fail = ff_q;

`ifdef EXERCISER_CAPTURE_EN
    logic [VEC_W-1:0] cap_q [NUM_VEC];

    // Cleared by reset only; a new run overwrites entries as it samples them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                cap_q[i] <= '0;
            end
        end else if (state_q == SAMPLE) begin
            cap_q[idx_q] <= xyz_in;
        end
    end

    assign cap_data = cap_q[cap_idx];
`endif

endmodule

// File: tb/tb_dp1_exerciser.sv
module tb_dp1_exerciser;

    localparam int S   = 2;
    localparam int RUN = 8 * (S + 1);
    localparam logic [2:0] GOLD [8] = '{3'b010, 3'b101, 3'b010, 3'b100,
                                       3'b011, 3'b001, 3'b000, 3'b001};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] xyz_in;
    logic [2:0] abc_out;
    logic       busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] first_fail;
`ifdef EXERCISER_CAPTURE_EN
    logic [2:0] cap_idx = 3'd0;
    logic [2:0] cap_data;
`endif

    logic [2:0] resp [8];   // behaviour of the DP1 instance under test, per abc

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] abc_tr  [1:64];
    logic       busy_tr [1:64];
    logic       done_tr [1:64];
    logic [3:0] err_tr  [1:64];
    logic       fv_tr   [1:64];
    int         done_cyc;

    dp1_exerciser #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .xyz_in     (xyz_in),
        .abc_out    (abc_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .first_fail (first_fail)
`ifdef EXERCISER_CAPTURE_EN
        ,
        .cap_idx    (cap_idx),
        .cap_data   (cap_data)
`endif
    );

    always #5 clk = ~clk;

    always_comb xyz_in = resp[abc_out];

    // Called at a negedge. Raises start, then records ncyc cycles after the edge
    // that samples it. start stays high if hold, and is re-raised at pulse_at.
    task automatic do_run(input int ncyc, input bit hold, input int pulse_at);
        start    = 1'b1;
        done_cyc = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            abc_tr[k]  = abc_out;
            busy_tr[k] = busy;
            done_tr[k] = done;
            err_tr[k]  = err_count;
            fv_tr[k]   = fail_valid;
            if (done && done_cyc == 0) done_cyc = k;
            start = hold || (k == pulse_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({abc_out, busy, done, pass, err_count, fail_valid, first_fail} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_values: got abc=%b busy=%b done=%b pass=%b err=%0d fv=%b ff=%b, want all zero",
                     abc_out, busy, done, pass, err_count, fail_valid, first_fail);
        end
`ifdef EXERCISER_CAPTURE_EN
        for (int v = 0; v < 8; v++) begin
            cap_idx = 3'(v);
            #1;
            n_chk++;
            if (cap_data !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_capture[%0d]: got %b want 000", v, cap_data);
            end
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_run();
        logic [2:0] want_abc;
        for (int v = 0; v < 8; v++) resp[v] = GOLD[v];
        do_run(RUN + 2, 1'b0, 0);
        for (int k = 1; k <= RUN + 1; k++) begin
            want_abc = (k <= RUN) ? 3'((k - 1) / (S + 1)) : 3'd0;
            n_chk++;
            if ({abc_tr[k], busy_tr[k], done_tr[k]} !== {want_abc, k <= RUN, k == RUN + 1}) begin
                n_fail++;
                $display("FAIL good_seq cycle %0d: got abc=%b busy=%b done=%b want abc=%b busy=%b done=%b",
                         k, abc_tr[k], busy_tr[k], done_tr[k], want_abc, k <= RUN, k == RUN + 1);
            end
        end
        n_chk++;
        if (done_cyc != RUN + 1) begin
            n_fail++;
            $display("FAIL good_done_cycle: got %0d want %0d", done_cyc, RUN + 1);
        end
        n_chk++;
        if ({pass, err_count, fail_valid} !== {1'b1, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL good_result: got pass=%b err=%0d fv=%b want pass=1 err=0 fv=0",
                     pass, err_count, fail_valid);
        end
    endtask

    // Runs one full pass against resp[] and checks results against a count
    // taken directly from comparing resp[] with the golden table.
    task automatic check_run(input string name);
        int         exp_err;
        logic       exp_fv;
        logic [2:0] exp_ff;
        exp_err = 0;
        exp_fv  = 1'b0;
        exp_ff  = 3'd0;
        for (int v = 0; v < 8; v++) begin
            if (resp[v] != GOLD[v]) begin
                if (!exp_fv) begin
                    exp_ff = 3'(v);
                    exp_fv = 1'b1;
                end
                exp_err++;
            end
        end
        do_run(RUN + 2, 1'b0, 0);
        n_chk++;
        if (done_cyc != RUN + 1) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, RUN + 1);
        end
        n_chk++;
        if ({err_count, fail_valid, pass} !== {4'(exp_err), exp_fv, exp_err == 0}) begin
            n_fail++;
            $display("FAIL %s counts: got err=%0d fv=%b pass=%b want err=%0d fv=%b pass=%b",
                     name, err_count, fail_valid, pass, exp_err, exp_fv, exp_err == 0);
        end
        if (exp_fv) begin
            n_chk++;
            if (first_fail !== exp_ff) begin
                n_fail++;
                $display("FAIL %s first_fail: got %b want %b", name, first_fail, exp_ff);
            end
        end
    endtask

    task automatic test_y_stuck();
        for (int v = 0; v < 8; v++) resp[v] = GOLD[v] & 3'b101;
        check_run("y_stuck0");
        n_chk++;
        if ({err_count, first_fail, pass} !== {4'd3, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL y_stuck0_fixed: got err=%0d ff=%b pass=%b want err=3 ff=000 pass=0",
                     err_count, first_fail, pass);
        end
    endtask

    task automatic test_all_ones();
        for (int v = 0; v < 8; v++) resp[v] = 3'b111;
        check_run("all_ones");
        n_chk++;
        if ({err_count, first_fail, pass} !== {4'd8, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL all_ones_fixed: got err=%0d ff=%b pass=%b want err=8 ff=000 pass=0",
                     err_count, first_fail, pass);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int v = 0; v < 8; v++) begin
                resp[v] = GOLD[v];
                if ($urandom_range(0, 2) == 0) resp[v] = GOLD[v] ^ 3'($urandom_range(1, 7));
            end
            check_run($sformatf("random%0d", it));
        end
    endtask

    task automatic test_start_held();
        logic [2:0] want_abc;
        for (int v = 0; v < 8; v++) resp[v] = 3'b111;
        do_run(RUN + 3, 1'b1, 10);
        for (int k = 1; k <= RUN + 3; k++) begin
            if (k <= RUN)          want_abc = 3'((k - 1) / (S + 1));
            else                   want_abc = 3'd0;
            n_chk++;
            if ({abc_tr[k], busy_tr[k], done_tr[k]} !==
                {want_abc, (k <= RUN) || (k == RUN + 3), k == RUN + 1}) begin
                n_fail++;
                $display("FAIL held_seq cycle %0d: got abc=%b busy=%b done=%b want abc=%b busy=%b done=%b",
                         k, abc_tr[k], busy_tr[k], done_tr[k], want_abc,
                         (k <= RUN) || (k == RUN + 3), k == RUN + 1);
            end
        end
        n_chk++;
        if ({err_tr[RUN + 2], fv_tr[RUN + 2]} !== {4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL held_results_hold: got err=%0d fv=%b want err=8 fv=1",
                     err_tr[RUN + 2], fv_tr[RUN + 2]);
        end
        n_chk++;
        if ({err_tr[RUN + 3], fv_tr[RUN + 3]} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL held_results_clear: got err=%0d fv=%b want err=0 fv=0",
                     err_tr[RUN + 3], fv_tr[RUN + 3]);
        end
        // Let the re-triggered run finish against a good DP1.
        for (int v = 0; v < 8; v++) resp[v] = GOLD[v];
        repeat (RUN) @(negedge clk);
        n_chk++;
        if ({done, pass, err_count} !== {1'b1, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL held_second_run: got done=%b pass=%b err=%0d want done=1 pass=1 err=0",
                     done, pass, err_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int  waited;
        bool_loop: begin end
        for (int v = 0; v < 8; v++) resp[v] = 3'b111;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (abc_out !== 3'd5 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_chk++;
        if (abc_out !== 3'd5) begin
            n_fail++;
            $display("FAIL midrun_reach_v5: got abc=%b want 101 within 40 cycles", abc_out);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({abc_out, busy, done, pass, err_count, fail_valid, first_fail} !== 14'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_values: got abc=%b busy=%b done=%b pass=%b err=%0d fv=%b ff=%b, want all zero",
                     abc_out, busy, done, pass, err_count, fail_valid, first_fail);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < RUN + 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_no_done cycle %0d: got done=%b busy=%b want 0 0", k, done, busy);
            end
        end
        for (int v = 0; v < 8; v++) resp[v] = GOLD[v];
        check_run("after_reset");
    endtask

`ifdef EXERCISER_CAPTURE_EN
    task automatic test_capture();
        for (int v = 0; v < 8; v++) resp[v] = GOLD[v];
        check_run("capture_run");
        for (int v = 0; v < 8; v++) begin
            cap_idx = 3'(v);
            #1;
            n_chk++;
            if (cap_data !== GOLD[v]) begin
                n_fail++;
                $display("FAIL capture[%0d]: got %b want %b", v, cap_data, GOLD[v]);
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int v = 0; v < 8; v++) resp[v] = GOLD[v];
        test_reset();
        test_good_run();
        test_y_stuck();
        test_all_ones();
        test_random();
        test_start_held();
        test_reset_midrun();
`ifdef EXERCISER_CAPTURE_EN
        test_capture();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
